// File: rtl/axil_sram_slave.sv
// axil_sram_slave: AXI4-Lite slave backed by a 64-bit word SRAM with configurable read latency
module axil_sram_slave #(
   parameter logic [63:0] ADDR_BASE  = 64'h0000_0000_8000_0000,
   parameter int          MEM_WORDS  = 1024,
   parameter int          RD_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [63:0] awaddr_i,
   input  logic [2:0]  awprot_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   input  logic [63:0] wdata_i,
   input  logic [7:0]  wstrb_i,
   output logic        bvalid_o,
   input  logic        bready_i,
   output logic [1:0]  bresp_o,
   input  logic        arvalid_i,
   output logic        arready_o,
   input  logic [63:0] araddr_i,
   input  logic [2:0]  arprot_i,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [63:0] rdata_o,
   output logic [1:0]  rresp_o
);
   localparam int          AW   = $clog2(MEM_WORDS);
   localparam int          CW   = $clog2(RD_LATENCY + 1);
   localparam logic [63:0] SPAN = 64'(MEM_WORDS) * 64'd8;
   typedef enum logic {W_COLLECT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
   wstate_t       wstate;
   rstate_t       rstate;
   logic [63:0]   mem [MEM_WORDS];
   logic          aw_full, w_full;
   logic [63:0]   aw_addr, w_data;
   logic [7:0]    w_strb;
   logic [CW-1:0] cnt;
   logic          aw_hs, w_hs, commit, w_in, r_in;
   logic [63:0]   wa, wd, w_off, r_off;
   logic [7:0]    ws;
   logic [AW-1:0] w_idx, r_idx;
   logic          unused;
   assign awready_o = !aw_full && wstate == W_COLLECT;
   assign wready_o  = !w_full && wstate == W_COLLECT;
   assign arready_o = rstate == R_IDLE;
   assign aw_hs     = awvalid_i && awready_o;
   assign w_hs      = wvalid_i && wready_o;
   // a buffer that fills on this edge is forwarded straight from the bus
   assign wa     = aw_full ? aw_addr : awaddr_i;
   assign wd     = w_full ? w_data : wdata_i;
   assign ws     = w_full ? w_strb : wstrb_i;
   assign commit = rst_n && wstate == W_COLLECT && (aw_full || aw_hs) && (w_full || w_hs);
   assign w_off  = wa - ADDR_BASE;
   assign r_off  = araddr_i - ADDR_BASE;
   assign w_in   = wa >= ADDR_BASE && w_off < SPAN;
   assign r_in   = araddr_i >= ADDR_BASE && r_off < SPAN;
   assign w_idx  = w_off[AW+2:3];
   assign r_idx  = r_off[AW+2:3];
   assign unused = ^{awprot_i, arprot_i, w_off[2:0], r_off[2:0], w_off[63:AW+3], r_off[63:AW+3]};
   // byte-lane commit into the array, which is deliberately never reset
   always_ff @(posedge clk)
      if (commit && w_in)
         for (int k = 0; k < 8; k++)
            if (ws[k]) mem[w_idx][8*k +: 8] <= wd[8*k +: 8];
   // write channel: collect AW and W independently, respond once both are held
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wstate  <= W_COLLECT;
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bvalid_o <= 1'b0;
         bresp_o <= 2'b00;
      end else if (wstate == W_COLLECT) begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr_i;
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= wdata_i;
            w_strb <= wstrb_i;
         end
         if (commit) begin
            wstate   <= W_RESP;
            bvalid_o <= 1'b1;
            bresp_o  <= w_in ? 2'b00 : 2'b10;
         end
      end else if (bready_i) begin
         wstate   <= W_COLLECT;
         bvalid_o <= 1'b0;
         aw_full  <= 1'b0;
         w_full   <= 1'b0;
      end
   // read channel: sample at AR handshake so a same-edge write is not seen, then delay
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rstate   <= R_IDLE;
         cnt      <= '0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         rresp_o  <= 2'b00;
      end else begin
         case (rstate)
            R_IDLE: if (arvalid_i) begin
               rdata_o  <= r_in ? mem[r_idx] : 64'd0;
               rresp_o  <= r_in ? 2'b00 : 2'b10;
               cnt      <= '0;
               rstate   <= RD_LATENCY == 1 ? R_RESP : R_WAIT;
               rvalid_o <= RD_LATENCY == 1;
            end
            R_WAIT: if (cnt == CW'(RD_LATENCY - 2)) begin
               rstate   <= R_RESP;
               rvalid_o <= 1'b1;
            end else cnt <= cnt + 1'b1;
            R_RESP: if (rready_i) begin
               rstate   <= R_IDLE;
               rvalid_o <= 1'b0;
            end
            default: rstate <= R_IDLE;
         endcase
      end
endmodule

// File: tb/tb_axil_sram_slave.sv
// tb_axil_sram_slave: scoreboard-driven scenario bench for the AXI4-Lite SRAM slave
module tb_axil_sram_slave;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          WORDS = 1024;
   localparam int          LAT   = 2;
   logic        clk, rst_n;
   logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
   logic        arvalid_i, arready_o, rvalid_o, rready_i;
   logic [63:0] awaddr_i, wdata_i, araddr_i, rdata_o;
   logic [2:0]  awprot_i, arprot_i;
   logic [7:0]  wstrb_i;
   logic [1:0]  bresp_o, rresp_o;
   typedef struct packed {logic [63:0] d; logic [1:0] r;} rexp_t;
   logic [1:0] exp_b[$];
   rexp_t      exp_r[$];
   int n_checks = 0;
   int n_fail = 0;

   axil_sram_slave #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
      .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
      .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic write_both(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      int n = 0;
      awaddr_i = a; wdata_i = d; wstrb_i = s; awvalid_i = 1'b1; wvalid_i = 1'b1;
      while (!(awready_o && wready_o) && n < 50) begin tick(); n++; end
      tick();
      awvalid_i = 1'b0; wvalid_i = 1'b0;
   endtask

   task automatic w_go(input logic [63:0] d, input logic [7:0] s);
      int n = 0;
      wdata_i = d; wstrb_i = s; wvalid_i = 1'b1;
      while (!wready_o && n < 50) begin tick(); n++; end
      tick();
      wvalid_i = 1'b0;
   endtask

   task automatic ar_go(input logic [63:0] a);
      int n = 0;
      araddr_i = a; arvalid_i = 1'b1;
      while (!arready_o && n < 50) begin tick(); n++; end
      tick();
      arvalid_i = 1'b0;
   endtask

   task automatic b_wait(output bit ok, output logic [1:0] r);
      int n = 0;
      while (!bvalid_o && n < 50) begin tick(); n++; end
      ok = bvalid_o; r = bresp_o;
      if (bready_i) tick();
   endtask

   task automatic r_wait(output bit ok, output logic [63:0] d, output logic [1:0] r, output int n);
      n = 0;
      while (!rvalid_o && n < 50) begin tick(); n++; end
      ok = rvalid_o; d = rdata_o; r = rresp_o;
      if (rready_i) tick();
   endtask

   task automatic test_reset;
      n_checks++;
      if ({awready_o, wready_o, arready_o, bvalid_o, rvalid_o} !== 5'b11100) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 11100", {awready_o, wready_o, arready_o, bvalid_o, rvalid_o});
      end
      n_checks++;
      if ({bresp_o, rresp_o} !== 4'b0000 || rdata_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h want 0", bresp_o, rresp_o, rdata_o);
      end
   endtask

   task automatic test_write_read;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      awaddr_i = BASE + 8; wdata_i = 64'h1122334455667788; wstrb_i = 8'hFF;
      awvalid_i = 1'b1; wvalid_i = 1'b1;
      exp_b.push_back(2'b00);
      tick();
      awvalid_i = 1'b0; wvalid_i = 1'b0;
      e = exp_b.pop_front();
      n_checks++;
      if (bvalid_o !== 1'b1 || bresp_o !== e) begin
         n_fail++; $display("FAIL b_next_cycle: got bvalid=%b bresp=%b want 1 %b", bvalid_o, bresp_o, e);
      end
      tick();
      n_checks++;
      if (bvalid_o !== 1'b0 || awready_o !== 1'b1 || wready_o !== 1'b1) begin
         n_fail++; $display("FAIL b_release: got bvalid=%b awready=%b wready=%b want 0 1 1", bvalid_o, awready_o, wready_o);
      end
      exp_r.push_back('{64'h1122334455667788, 2'b00});
      ar_go(BASE + 8);
      r_wait(ok, d, r, n);
      n_checks++;
      if (!ok || n != LAT - 1) begin
         n_fail++; $display("FAIL r_latency: got ok=%b extra_cycles=%0d want %0d", ok, n, LAT - 1);
      end
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_basic: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
   endtask

   task automatic test_w_before_aw;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      w_go(64'hAAAAAAAABBBBBBBB, 8'h0F);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (wready_o !== 1'b0 || bvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL w_wait_aw: got wready=%b bvalid=%b want 0 0", wready_o, bvalid_o);
         end
         if (i < 2) tick();
      end
      awaddr_i = BASE + 8; awvalid_i = 1'b1;
      exp_b.push_back(2'b00);
      tick();
      awvalid_i = 1'b0;
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_w_first: got ok=%b bresp=%b want %b", ok, r, e);
      end
      exp_r.push_back('{64'h11223344BBBBBBBB, 2'b00});
      ar_go(BASE + 8);
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_partial_strb: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
   endtask

   task automatic test_zero_strobe;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      exp_b.push_back(2'b00);
      write_both(BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_zero_strb: got ok=%b bresp=%b want %b", ok, r, e);
      end
      exp_r.push_back('{64'h11223344BBBBBBBB, 2'b00});
      ar_go(BASE + 8);
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_zero_strb: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
   endtask

   task automatic test_out_of_range;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      logic [63:0] wa[4];
      logic [63:0] wv[4];
      logic [1:0]  wr[4];
      logic [63:0] ra[4];
      wa = '{BASE, BASE + 64'h1FF8, BASE + 64'h2000, BASE - 8};
      wv = '{64'h0123456789ABCDEF, 64'hCAFEF00D12345678, 64'hDEADBEEFDEADBEEF, 64'h5A5A5A5A5A5A5A5A};
      wr = '{2'b00, 2'b00, 2'b10, 2'b10};
      for (int i = 0; i < 4; i++) begin
         exp_b.push_back(wr[i]);
         write_both(wa[i], wv[i], 8'hFF);
         b_wait(ok, r);
         e = exp_b.pop_front();
         n_checks++;
         if (!ok || r !== e) begin
            n_fail++; $display("FAIL b_range_%0d: got ok=%b bresp=%b want %b", i, ok, r, e);
         end
      end
      ra = '{BASE - 8, BASE + 64'h2000, BASE, BASE + 64'h1FF8};
      exp_r.push_back('{64'd0, 2'b10});
      exp_r.push_back('{64'd0, 2'b10});
      exp_r.push_back('{64'h0123456789ABCDEF, 2'b00});
      exp_r.push_back('{64'hCAFEF00D12345678, 2'b00});
      for (int i = 0; i < 4; i++) begin
         ar_go(ra[i]);
         r_wait(ok, d, r, n);
         x = exp_r.pop_front();
         n_checks++;
         if (!ok || d !== x.d || r !== x.r) begin
            n_fail++; $display("FAIL r_range_%0d: got %h/%b want %h/%b", i, d, r, x.d, x.r);
         end
      end
   endtask

   task automatic test_backpressure;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      bready_i = 1'b0;
      exp_b.push_back(2'b00);
      write_both(BASE + 64'h10, 64'h5555666677778888, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bvalid_o !== 1'b1 || bresp_o !== exp_b[0] || awready_o !== 1'b0 || wready_o !== 1'b0) begin
            n_fail++; $display("FAIL b_hold_%0d: got bvalid=%b bresp=%b awready=%b wready=%b want 1 %b 0 0", i, bvalid_o, bresp_o, awready_o, wready_o, exp_b[0]);
         end
         tick();
      end
      bready_i = 1'b1;
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_after_hold: got ok=%b bresp=%b want %b", ok, r, e);
      end
      rready_i = 1'b0;
      exp_r.push_back('{64'h5555666677778888, 2'b00});
      ar_go(BASE + 64'h10);
      r_wait(ok, d, r, n);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (rvalid_o !== 1'b1 || rdata_o !== exp_r[0].d || rresp_o !== exp_r[0].r || arready_o !== 1'b0) begin
            n_fail++; $display("FAIL r_hold_%0d: got rvalid=%b rdata=%h rresp=%b arready=%b want 1 %h %b 0", i, rvalid_o, rdata_o, rresp_o, arready_o, exp_r[0].d, exp_r[0].r);
         end
         tick();
      end
      rready_i = 1'b1;
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_after_hold: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
      n_checks++;
      if (arready_o !== 1'b1 || rvalid_o !== 1'b0) begin
         n_fail++; $display("FAIL r_release: got arready=%b rvalid=%b want 1 0", arready_o, rvalid_o);
      end
   endtask

   task automatic test_same_edge;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      exp_b.push_back(2'b00);
      write_both(BASE + 64'h18, 64'h0000_1111_2222_3333, 8'hFF);
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_preload: got ok=%b bresp=%b want %b", ok, r, e);
      end
      w_go(64'h9999_8888_7777_6666, 8'hFF);
      awaddr_i = BASE + 64'h18; awvalid_i = 1'b1;
      araddr_i = BASE + 64'h18; arvalid_i = 1'b1;
      exp_b.push_back(2'b00);
      exp_r.push_back('{64'h0000_1111_2222_3333, 2'b00});
      tick();
      awvalid_i = 1'b0; arvalid_i = 1'b0;
      n_checks++;
      if (bvalid_o !== 1'b1 || arready_o !== 1'b0) begin
         n_fail++; $display("FAIL same_edge_hs: got bvalid=%b arready=%b want 1 0", bvalid_o, arready_o);
      end
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_same_edge: got ok=%b bresp=%b want %b", ok, r, e);
      end
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_same_edge_old: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
      exp_r.push_back('{64'h9999_8888_7777_6666, 2'b00});
      ar_go(BASE + 64'h18);
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_same_edge_new: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
   endtask

   task automatic test_reset_midflight;
      bit ok; logic [1:0] r, e; logic [63:0] d; int n; rexp_t x;
      bready_i = 1'b0;
      exp_b.push_back(2'b10);
      write_both(BASE + 64'h2008, 64'h1234, 8'hFF);
      exp_r.push_back('{64'h11223344BBBBBBBB, 2'b00});
      ar_go(BASE + 8);
      n_checks++;
      if (bvalid_o !== 1'b1 || bresp_o !== exp_b[0] || rvalid_o !== 1'b0 || arready_o !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset: got bvalid=%b bresp=%b rvalid=%b arready=%b want 1 %b 0 0", bvalid_o, bresp_o, rvalid_o, arready_o, exp_b[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      exp_b.delete();
      exp_r.delete();
      test_reset();
      tick();
      rst_n = 1'b1;
      bready_i = 1'b1;
      tick();
      exp_b.push_back(2'b00);
      write_both(BASE + 64'h20, 64'hFEDCBA9876543210, 8'hFF);
      b_wait(ok, r);
      e = exp_b.pop_front();
      n_checks++;
      if (!ok || r !== e) begin
         n_fail++; $display("FAIL b_post_reset: got ok=%b bresp=%b want %b", ok, r, e);
      end
      exp_r.push_back('{64'hFEDCBA9876543210, 2'b00});
      ar_go(BASE + 64'h20);
      r_wait(ok, d, r, n);
      x = exp_r.pop_front();
      n_checks++;
      if (!ok || d !== x.d || r !== x.r) begin
         n_fail++; $display("FAIL r_post_reset: got %h/%b want %h/%b", d, r, x.d, x.r);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
      bready_i = 1'b1; rready_i = 1'b1;
      awaddr_i = '0; araddr_i = '0; wdata_i = '0; wstrb_i = '0;
      awprot_i = 3'b010; arprot_i = 3'b101;
      tick(3);
      test_reset();
      rst_n = 1'b1;
      tick();
      test_write_read();
      test_w_before_aw();
      test_zero_strobe();
      test_out_of_range();
      test_backpressure();
      test_same_edge();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of 64-bit words (power of 2, >=2).
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from AR handshake to rvalid_o rising (>=1).
REQ-004 Port list:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- awvalid_i / awready_o  in / out  1 / 1  write-address handshake.
- awaddr_i / awprot_i  in  64 / 3  write byte address; prot ignored.
- wvalid_i / wready_o  in / out  1 / 1  write-data handshake.
- wdata_i / wstrb_i  in  64 / 8  write data; byte lane enables.
- bvalid_o / bready_i  out / in  1 / 1  write-response handshake.
- bresp_o  out  2  write response.
- arvalid_i / arready_o  in / out  1 / 1  read-address handshake.
- araddr_i / arprot_i  in  64 / 3  read byte address; prot ignored.
- rvalid_o / rready_i  out / in  1 / 1  read-data handshake.
- rdata_o / rresp_o  out  64 / 2  read data; read response.

Function
REQ-005 Handshake on a channel SHALL occur on a rising edge where valid and ready are both 1; outputs SHALL depend only on registers (no combinational input-to-output path).
REQ-006 Address decode: in range iff ADDR_BASE <= addr < ADDR_BASE+MEM_WORDS*8; word index = (addr-ADDR_BASE)>>3; addr[2:0] ignored.
REQ-007 Write path SHALL hold one AW buffer and one W buffer, each captured independently; awready_o = AW buffer empty and write FSM in W_COLLECT; wready_o likewise for W buffer.
REQ-008 Write FSM states W_COLLECT, W_RESP; W_COLLECT->W_RESP on the cycle both buffers are full (including both captured on the same edge); commit happens on that transition.
REQ-009 Commit: if in range, byte lane k of the word SHALL be updated with wdata[8k+7:8k] iff wstrb[k]=1; bresp_o=2'b00; if out of range, memory unchanged, bresp_o=2'b10 (SLVERR).
REQ-010 W_RESP SHALL drive bvalid_o=1 with stable bresp_o until B handshake, then clear both buffers and return to W_COLLECT; bvalid_o first asserted the cycle after the later of AW/W handshake.
REQ-011 wstrb=8'h00 in range SHALL leave memory unchanged and return OKAY.
REQ-012 Read FSM states R_IDLE, R_WAIT, R_RESP; arready_o=1 only in R_IDLE.
REQ-013 AR handshake SHALL sample the addressed word (0 and rresp 2'b10 if out of range, else rresp 2'b00) and go to R_WAIT, or straight to R_RESP when RD_LATENCY=1.
REQ-014 R_WAIT SHALL count RD_LATENCY-1 cycles, then enter R_RESP; rvalid_o rises exactly RD_LATENCY cycles after the AR handshake edge.
REQ-015 R_RESP SHALL hold rvalid_o, rdata_o, rresp_o stable until R handshake, then return to R_IDLE; back-to-back AR accepted no earlier than the cycle after R handshake.
REQ-016 Read and write channels SHALL operate concurrently; a write committing on the same edge as an AR handshake to the same word SHALL NOT be visible to that read (old data returned).
REQ-017 One outstanding transaction per channel; no ID, burst or ordering support.

Reset
REQ-018 On rst_n=0 (any time, including mid-transaction): awready_o=1, wready_o=1, arready_o=1, bvalid_o=0, rvalid_o=0, bresp_o=0, rresp_o=0, rdata_o=0, both FSMs in initial state, buffers empty, latency counter 0; in-flight transactions dropped.
REQ-019 Memory array contents SHALL NOT be reset.

Verification
REQ-020 AW 0x8000_0008 and W 0x1122334455667788 strb 8'hFF same cycle, bready=1 -> bvalid next cycle, bresp 00; then AR 0x8000_0008 -> rvalid 2 cycles later, rdata 0x1122334455667788, rresp 00.
REQ-021 W before AW by 3 cycles, then strb 8'h0F data 0xAAAAAAAABBBBBBBB over the word above -> readback 0x11223344BBBBBBBB; wready_o=0 while waiting for AW.
REQ-022 AR 0x7FFF_FFF8 and AW 0x8000_2000 (MEM_WORDS=1024) -> rresp 10 rdata 0; bresp 10; memory unchanged.
REQ-023 rready_i=0 for 5 cycles during R_RESP, bready_i=0 for 4 cycles during W_RESP -> valids and payloads held stable, arready_o/awready_o=0 throughout.
REQ-024 Write commit and AR to the same word on the same edge -> read returns pre-write data; next read returns new data.
REQ-025 rst_n pulsed low while in R_WAIT and W_RESP -> all outputs at REQ-018 values asynchronously; next transactions complete normally.
